// File: rtl/writeback.sv
// ---------------------------------------------------------------------------
// writeback
// Final pipeline stage of the core. It retires execute results into the
// architectural register file and provides two combinational read ports to
// decode, with same-cycle bypass of the retiring write. It also sequences
// control-flow redirects (a one-cycle FLUSH) and exceptions (a sticky HALT).
//
// Ports
//   clk, rst                : clock; asynchronous active-low reset
//   result_valid/ready      : execute result handshake; ready is 1 whenever
//                             the block is out of reset, so results never stall
//   result_rd/we/val        : destination register, write enable, write data
//   result_pc               : PC of the producing instruction
//   result_redirect/target  : taken control transfer and its target PC
//   result_exc              : invalid-instruction exception
//   rs1_addr/rs2_addr       : decode read addresses
//   rs1_data/rs2_data       : decode read data (combinational, bypassed)
//   flush, redirect_pc      : pipeline flush and fetch restart PC
//   trap, trap_pc           : halted on exception, PC of the faulting instr
//   instret                 : 64-bit retired instruction counter
// ---------------------------------------------------------------------------
module writeback #(
    parameter int XLEN = 32,
    parameter int NREG = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    result_valid,
    output logic                    result_ready,
    input  logic [$clog2(NREG)-1:0] result_rd,
    input  logic                    result_we,
    input  logic [XLEN-1:0]         result_val,
    input  logic [XLEN-1:0]         result_pc,
    input  logic                    result_redirect,
    input  logic [XLEN-1:0]         result_target,
    input  logic                    result_exc,
    input  logic [$clog2(NREG)-1:0] rs1_addr,
    input  logic [$clog2(NREG)-1:0] rs2_addr,
    output logic [XLEN-1:0]         rs1_data,
    output logic [XLEN-1:0]         rs2_data,
    output logic                    flush,
    output logic [XLEN-1:0]         redirect_pc,
    output logic                    trap,
    output logic [XLEN-1:0]         trap_pc,
    output logic [63:0]             instret
);

    localparam int AW = $clog2(NREG);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        FLUSH = 2'd1,
        HALT  = 2'd2
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [XLEN-1:0] regs [NREG];
    logic            retire;
    logic            wr_en;

    // The result channel never back-pressures; it is only closed while the
    // block is held in reset.
    assign result_ready = rst;

    // A result only takes effect in RUN. Anything arriving during FLUSH or
    // HALT belongs to squashed or post-fault instructions and is dropped.
    // Gating with rst keeps a result presented during reset from reaching
    // the bypass path.
    assign retire = rst & result_valid & (state == RUN);

    // The faulting instruction must not update architectural state, and x0
    // is hardwired to zero, so neither case produces a write.
    assign wr_en = retire & result_we & ~result_exc & (result_rd != '0);

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= RUN;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and flush/trap outputs. An exception takes priority over a
    // redirect carried by the same result. HALT also keeps flush asserted so
    // the front end stays squashed until reset.
    always_comb begin
        state_next = state;
        flush      = 1'b0;
        trap       = 1'b0;
        unique case (state)
            RUN: begin
                if (retire && result_exc) begin
                    state_next = HALT;
                end else if (retire && result_redirect) begin
                    state_next = FLUSH;
                end
            end
            FLUSH: begin
                flush      = 1'b1;
                state_next = RUN;
            end
            HALT: begin
                flush = 1'b1;
                trap  = 1'b1;
            end
            default: begin
                state_next = RUN;
            end
        endcase
    end

    // Redirect target, trap PC and retired-instruction counter. The
    // counter includes redirecting instructions but not the faulting one.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            redirect_pc <= '0;
            trap_pc     <= '0;
            instret     <= '0;
        end else begin
            if (retire && !result_exc) begin
                instret <= instret + 64'd1;
                if (result_redirect) begin
                    redirect_pc <= result_target;
                end
            end
            if (retire && result_exc) begin
                trap_pc <= result_pc;
            end
        end
    end

    // Architectural register file. A redirecting instruction still writes
    // its destination so JAL/JALR link values land.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_en) begin
            regs[result_rd] <= result_val;
        end
    end

    // Read ports. The retiring write is forwarded in the same cycle so decode
    // sees it with zero latency; x0 always reads zero.
    always_comb begin
        rs1_data = '0;
        if (rs1_addr != '0) begin
            if (wr_en && (result_rd == rs1_addr)) begin
                rs1_data = result_val;
            end else begin
                rs1_data = regs[rs1_addr];
            end
        end
    end

    always_comb begin
        rs2_data = '0;
        if (rs2_addr != '0) begin
            if (wr_en && (result_rd == rs2_addr)) begin
                rs2_data = result_val;
            end else begin
                rs2_data = regs[rs2_addr];
            end
        end
    end

    logic [AW-1:0] unused_aw;
    assign unused_aw = '0;

endmodule

// File: tb/tb_writeback.sv
// ---------------------------------------------------------------------------
// tb_writeback
// Directed self-checking bench for writeback. Inputs change one time unit
// after the rising edge; outputs are sampled one further time unit later.
// ---------------------------------------------------------------------------
module tb_writeback;

    logic        clk;
    logic        rst;
    logic        result_valid;
    logic        result_ready;
    logic [4:0]  result_rd;
    logic        result_we;
    logic [31:0] result_val;
    logic [31:0] result_pc;
    logic        result_redirect;
    logic [31:0] result_target;
    logic        result_exc;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic        flush;
    logic [31:0] redirect_pc;
    logic        trap;
    logic [31:0] trap_pc;
    logic [63:0] instret;

    int checks = 0;
    int fails  = 0;

    writeback #(.XLEN(32), .NREG(32)) dut (
        .clk             (clk),
        .rst             (rst),
        .result_valid    (result_valid),
        .result_ready    (result_ready),
        .result_rd       (result_rd),
        .result_we       (result_we),
        .result_val      (result_val),
        .result_pc       (result_pc),
        .result_redirect (result_redirect),
        .result_target   (result_target),
        .result_exc      (result_exc),
        .rs1_addr        (rs1_addr),
        .rs2_addr        (rs2_addr),
        .rs1_data        (rs1_data),
        .rs2_data        (rs2_data),
        .flush           (flush),
        .redirect_pc     (redirect_pc),
        .trap            (trap),
        .trap_pc         (trap_pc),
        .instret         (instret)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance to one time unit past the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one result on the execute channel.
    task automatic applyStimulus(input logic v, input logic [4:0] rd, input logic we,
                                 input logic [31:0] val, input logic [31:0] pc,
                                 input logic redir, input logic [31:0] tgt,
                                 input logic exc);
        result_valid    = v;
        result_rd       = rd;
        result_we       = we;
        result_val      = val;
        result_pc       = pc;
        result_redirect = redir;
        result_target   = tgt;
        result_exc      = exc;
    endtask

    task automatic idle();
        applyStimulus(1'b0, 5'd0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        rs1_addr = 5'd5;
        rs2_addr = 5'd0;
        applyStimulus(1'b1, 5'd5, 1'b1, 32'hCAFE_0001, 32'h4, 1'b1, 32'h44, 1'b0);
        #1 rst = 1'b0;
        tick();
        checks++;
        if (result_ready !== 1'b0) begin
            fails++; $display("[TB] FAIL reset_ready: got %b expected 0", result_ready);
        end
        checks++;
        if (flush !== 1'b0 || trap !== 1'b0) begin
            fails++; $display("[TB] FAIL reset_flush_trap: got %b/%b expected 0/0", flush, trap);
        end
        checks++;
        if (redirect_pc !== 32'h0 || trap_pc !== 32'h0) begin
            fails++; $display("[TB] FAIL reset_pcs: got %h/%h expected 0/0", redirect_pc, trap_pc);
        end
        checks++;
        if (instret !== 64'h0) begin
            fails++; $display("[TB] FAIL reset_instret: got %0d expected 0", instret);
        end
        checks++;
        if (rs1_data !== 32'h0) begin
            fails++; $display("[TB] FAIL reset_rs1: got %h expected 0", rs1_data);
        end
        idle();
        rst = 1'b1;
        tick();
        checks++;
        if (result_ready !== 1'b1 || instret !== 64'h0 || flush !== 1'b0) begin
            fails++; $display("[TB] FAIL post_reset: got ready=%b instret=%0d flush=%b expected 1/0/0",
                              result_ready, instret, flush);
        end
    endtask

    task automatic test_bypass();
        rs1_addr = 5'd5;
        rs2_addr = 5'd0;
        applyStimulus(1'b1, 5'd5, 1'b1, 32'hDEAD_BEEF, 32'h100, 1'b0, 32'h0, 1'b0);
        #1;
        checks++;
        if (rs1_data !== 32'hDEAD_BEEF) begin
            fails++; $display("[TB] FAIL bypass_same_cycle: got %h expected deadbeef", rs1_data);
        end
        checks++;
        if (rs2_data !== 32'h0) begin
            fails++; $display("[TB] FAIL bypass_rs2_x0: got %h expected 0", rs2_data);
        end
        tick();
        idle();
        rs2_addr = 5'd5;
        #1;
        checks++;
        if (rs1_data !== 32'hDEAD_BEEF || rs2_data !== 32'hDEAD_BEEF) begin
            fails++; $display("[TB] FAIL bypass_stored: got %h/%h expected deadbeef", rs1_data, rs2_data);
        end
        checks++;
        if (instret !== 64'd1) begin
            fails++; $display("[TB] FAIL bypass_instret: got %0d expected 1", instret);
        end
    endtask

    task automatic test_x0_and_no_we();
        rs1_addr = 5'd0;
        applyStimulus(1'b1, 5'd0, 1'b1, 32'h0000_1234, 32'h104, 1'b0, 32'h0, 1'b0);
        #1;
        checks++;
        if (rs1_data !== 32'h0) begin
            fails++; $display("[TB] FAIL x0_bypass: got %h expected 0", rs1_data);
        end
        tick();
        applyStimulus(1'b1, 5'd6, 1'b0, 32'h0000_0055, 32'h108, 1'b0, 32'h0, 1'b0);
        rs2_addr = 5'd6;
        #1;
        checks++;
        if (rs1_data !== 32'h0 || instret !== 64'd2) begin
            fails++; $display("[TB] FAIL x0_stored: got rs1=%h instret=%0d expected 0/2", rs1_data, instret);
        end
        checks++;
        if (rs2_data !== 32'h0) begin
            fails++; $display("[TB] FAIL no_we_bypass: got %h expected 0", rs2_data);
        end
        tick();
        idle();
        #1;
        checks++;
        if (rs2_data !== 32'h0 || instret !== 64'd3) begin
            fails++; $display("[TB] FAIL no_we_stored: got rs2=%h instret=%0d expected 0/3", rs2_data, instret);
        end
    endtask

    task automatic test_redirect();
        applyStimulus(1'b1, 5'd1, 1'b1, 32'h0000_0011, 32'h10, 1'b1, 32'h80, 1'b0);
        tick();
        applyStimulus(1'b1, 5'd2, 1'b1, 32'h0000_0022, 32'h14, 1'b0, 32'h0, 1'b0);
        rs1_addr = 5'd2;
        rs2_addr = 5'd1;
        #1;
        checks++;
        if (flush !== 1'b1 || trap !== 1'b0 || redirect_pc !== 32'h80) begin
            fails++; $display("[TB] FAIL flush_state: got flush=%b trap=%b pc=%h expected 1/0/80",
                              flush, trap, redirect_pc);
        end
        checks++;
        if (rs1_data !== 32'h0) begin
            fails++; $display("[TB] FAIL flush_no_bypass: got %h expected 0", rs1_data);
        end
        checks++;
        if (rs2_data !== 32'h11 || instret !== 64'd4) begin
            fails++; $display("[TB] FAIL redirect_link: got rs2=%h instret=%0d expected 11/4", rs2_data, instret);
        end
        tick();
        applyStimulus(1'b1, 5'd3, 1'b1, 32'h0000_0033, 32'h80, 1'b0, 32'h0, 1'b0);
        rs2_addr = 5'd3;
        #1;
        checks++;
        if (flush !== 1'b0 || rs1_data !== 32'h0 || instret !== 64'd4) begin
            fails++; $display("[TB] FAIL flush_dropped: got flush=%b rs1=%h instret=%0d expected 0/0/4",
                              flush, rs1_data, instret);
        end
        checks++;
        if (rs2_data !== 32'h33) begin
            fails++; $display("[TB] FAIL run_after_flush: got %h expected 33", rs2_data);
        end
        tick();
        idle();
        #1;
        checks++;
        if (rs2_data !== 32'h33 || instret !== 64'd5) begin
            fails++; $display("[TB] FAIL run_retire: got rs2=%h instret=%0d expected 33/5", rs2_data, instret);
        end
    endtask

    task automatic test_back_to_back();
        applyStimulus(1'b1, 5'd7, 1'b1, 32'h7777_0007, 32'h84, 1'b0, 32'h0, 1'b0);
        tick();
        applyStimulus(1'b1, 5'd8, 1'b1, 32'h8888_0008, 32'h88, 1'b0, 32'h0, 1'b0);
        rs1_addr = 5'd7;
        rs2_addr = 5'd8;
        #1;
        checks++;
        if (rs1_data !== 32'h7777_0007 || rs2_data !== 32'h8888_0008) begin
            fails++; $display("[TB] FAIL b2b_read: got %h/%h expected 77770007/88880008", rs1_data, rs2_data);
        end
        tick();
        idle();
        #1;
        checks++;
        if (rs2_data !== 32'h8888_0008 || instret !== 64'd7) begin
            fails++; $display("[TB] FAIL b2b_stored: got rs2=%h instret=%0d expected 88880008/7", rs2_data, instret);
        end
    endtask

    task automatic test_wrap();
        force dut.instret = 64'hFFFF_FFFF_FFFF_FFFF;
        #1;
        release dut.instret;
        #1;
        checks++;
        if (instret !== 64'hFFFF_FFFF_FFFF_FFFF) begin
            fails++; $display("[TB] FAIL wrap_preload: got %h expected ffffffffffffffff", instret);
        end
        applyStimulus(1'b1, 5'd9, 1'b1, 32'h0000_0099, 32'h8C, 1'b0, 32'h0, 1'b0);
        tick();
        idle();
        #1;
        checks++;
        if (instret !== 64'h0) begin
            fails++; $display("[TB] FAIL wrap_instret: got %h expected 0", instret);
        end
    endtask

    task automatic test_exception();
        applyStimulus(1'b1, 5'd10, 1'b1, 32'h0000_00AA, 32'h40, 1'b1, 32'h100, 1'b1);
        rs1_addr = 5'd10;
        rs2_addr = 5'd11;
        #1;
        checks++;
        if (rs1_data !== 32'h0) begin
            fails++; $display("[TB] FAIL exc_no_bypass: got %h expected 0", rs1_data);
        end
        tick();
        applyStimulus(1'b1, 5'd11, 1'b1, 32'h0000_00BB, 32'h44, 1'b1, 32'h200, 1'b0);
        #1;
        checks++;
        if (trap !== 1'b1 || flush !== 1'b1 || trap_pc !== 32'h40) begin
            fails++; $display("[TB] FAIL exc_halt: got trap=%b flush=%b pc=%h expected 1/1/40", trap, flush, trap_pc);
        end
        checks++;
        if (redirect_pc !== 32'h80 || instret !== 64'h0 || rs1_data !== 32'h0) begin
            fails++; $display("[TB] FAIL exc_side_effects: got rpc=%h instret=%0d rs1=%h expected 80/0/0",
                              redirect_pc, instret, rs1_data);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
        end
        checks++;
        if (trap !== 1'b1 || flush !== 1'b1 || result_ready !== 1'b1) begin
            fails++; $display("[TB] FAIL halt_sticky: got trap=%b flush=%b ready=%b expected 1/1/1",
                              trap, flush, result_ready);
        end
        checks++;
        if (rs2_data !== 32'h0 || instret !== 64'h0 || trap_pc !== 32'h40) begin
            fails++; $display("[TB] FAIL halt_ignored: got rs2=%h instret=%0d tpc=%h expected 0/0/40",
                              rs2_data, instret, trap_pc);
        end
    endtask

    task automatic test_reset_in_halt();
        idle();
        rs1_addr = 5'd5;
        rs2_addr = 5'd1;
        rst = 1'b0;
        #1;
        checks++;
        if (trap !== 1'b0 || flush !== 1'b0 || instret !== 64'h0 || trap_pc !== 32'h0) begin
            fails++; $display("[TB] FAIL halt_reset: got trap=%b flush=%b instret=%0d tpc=%h expected 0/0/0/0",
                              trap, flush, instret, trap_pc);
        end
        checks++;
        if (rs1_data !== 32'h0 || rs2_data !== 32'h0) begin
            fails++; $display("[TB] FAIL halt_reset_regs: got %h/%h expected 0/0", rs1_data, rs2_data);
        end
        tick();
        rst = 1'b1;
        tick();
        applyStimulus(1'b1, 5'd12, 1'b1, 32'h0000_0CCC, 32'h0, 1'b0, 32'h0, 1'b0);
        rs1_addr = 5'd12;
        tick();
        idle();
        #1;
        checks++;
        if (rs1_data !== 32'h0000_0CCC || instret !== 64'd1 || trap !== 1'b0) begin
            fails++; $display("[TB] FAIL run_after_reset: got rs1=%h instret=%0d trap=%b expected ccc/1/0",
                              rs1_data, instret, trap);
        end
    endtask

    initial begin
        idle();
        rst = 1'b1;
        rs1_addr = 5'd0;
        rs2_addr = 5'd0;
        test_reset();
        test_bypass();
        test_x0_and_no_we();
        test_redirect();
        test_back_to_back();
        test_wrap();
        test_exception();
        test_reset_in_halt();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/writeback.md
WRITEBACK -- requirements
Module: writeback

Interface
REQ-001 Parameter XLEN, default 32, SHALL set data/PC width.
REQ-002 Parameter NREG, default 32, SHALL set architectural register count; index width is log2(NREG) (5 at default).
REQ-003 clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-low.
REQ-005 result_valid  in  1  execute result present.
REQ-006 result_ready  out  1  result accepted.
REQ-007 result_rd  in  5  destination register.
REQ-008 result_we  in  1  destination write enable.
REQ-009 result_val  in  XLEN  destination value.
REQ-010 result_pc  in  XLEN  PC of the producing instruction.
REQ-011 result_redirect  in  1  control transfer taken / mispredict.
REQ-012 result_target  in  XLEN  redirect target PC.
REQ-013 result_exc  in  1  invalid-instruction exception.
REQ-014 rs1_addr, rs2_addr  in  5 each  decode-side read addresses.
REQ-015 rs1_data, rs2_data  out  XLEN each  read data, combinational.
REQ-016 flush  out  1  pipeline flush to fetch/decode/execute.
REQ-017 redirect_pc  out  XLEN  fetch restart PC, valid while flush=1 in FLUSH.
REQ-018 trap  out  1  core halted on exception.
REQ-019 trap_pc  out  XLEN  PC of the faulting instruction.
REQ-020 instret  out  64  retired instruction count.

Function
REQ-021 result_ready SHALL be 1 in every cycle after reset; the result channel is unblockable.
REQ-022 A result SHALL retire when result_valid=1 and state is RUN; results in FLUSH or HALT SHALL be discarded with no side effects.
REQ-023 FSM states SHALL be RUN, FLUSH, HALT.
REQ-024 RUN -> HALT on a retiring result with result_exc=1; RUN -> FLUSH on a retiring result with result_redirect=1 and result_exc=0; FLUSH -> RUN unconditionally after one cycle; HALT SHALL persist until reset.
REQ-025 result_exc and result_redirect both 1: exception SHALL win; no redirect SHALL occur.
REQ-026 On retire with result_we=1, result_exc=0 and result_rd!=0, the register file SHALL store result_val at the clock edge.
REQ-027 Register 0 SHALL always read 0 and SHALL never be written.
REQ-028 rsN_data SHALL bypass: if a write to rsN_addr (nonzero) retires in the current cycle, rsN_data SHALL equal result_val in that cycle; otherwise it SHALL equal the stored value.
REQ-029 A redirecting instruction's register write SHALL still occur (JAL/JALR link).
REQ-030 Entering FLUSH, redirect_pc SHALL be registered from result_target; flush SHALL be 1 for exactly the FLUSH cycle.
REQ-031 Entering HALT, trap_pc SHALL be registered from result_pc; trap and flush SHALL be 1 in every HALT cycle.
REQ-032 instret SHALL increment by 1 per retiring non-exception result, wrapping modulo 2^64; the faulting instruction SHALL NOT count.
REQ-033 Retire-to-architectural-visibility latency SHALL be 0 cycles through bypass, 1 cycle through storage.

Reset
REQ-034 While rst=0: state=RUN, flush=0, trap=0, redirect_pc=0, trap_pc=0, instret=0, result_ready=0.
REQ-035 All register-file entries SHALL reset to 0.
REQ-036 Reset asserted mid-FLUSH or in HALT SHALL return to RUN immediately and asynchronously; no pending write SHALL complete.

Verification
REQ-037 Write rd=5, val=0xDEADBEEF, rs1_addr=5 same cycle -> rs1_data=0xDEADBEEF that cycle and the next; instret=1.
REQ-038 Write rd=0, val=0x1234 -> rs1_addr=0 reads 0; instret increments.
REQ-039 Redirect result, target=0x80 followed by valid result next cycle -> flush=1, redirect_pc=0x80 for one cycle; second result dropped (no write, instret unchanged); RUN the cycle after.
REQ-040 Exception at pc=0x40 with redirect=1, we=1 -> trap=1, trap_pc=0x40, flush held, no write, no instret increment; later results ignored.
REQ-041 Preload instret near 2^64-1 via 2^64-1 forced state, retire one -> instret=0.
REQ-042 Assert rst in HALT -> trap=0, flush=0, instret=0, all registers 0, state RUN after release.
